// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot-time loader that sits in front of the instruction memory. It receives
// a byte stream made of a length header followed by opcode/literal byte
// pairs, packs each pair into a 15-bit word {opcode[6:0], literal[7:0]} and
// writes the words to consecutive instruction-memory addresses from 0.
// The CPU is held in reset until the whole program has been written.
// Malformed streams (opcode byte with bit 7 set) and streams that stall
// inside the program body for TIMEOUT cycles abort the load into ERR.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [14:0] im_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  count
);

    // Last timer value that is still tolerated; reaching it idle aborts.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_OPC   = 3'd2,
        S_LIT   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_rx_ready;
    logic        r_im_we;
    logic [7:0]  r_im_addr;
    logic [14:0] r_im_wdata;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [8:0]  r_count;
    logic [8:0]  r_len;      // program length in words, 1..256
    logic [15:0] r_timer;    // idle cycles since the last accepted byte
    logic [6:0]  r_opcode;   // opcode waiting for its literal

    logic        w_xfer;
    logic        w_timer_expired;
    logic [8:0]  w_count_inc;
    logic        w_last_word;

    assign w_xfer          = rx_valid & r_rx_ready;
    assign w_timer_expired = (r_timer == TMO_LAST);
    assign w_count_inc     = r_count + 9'd1;
    assign w_last_word     = (w_count_inc == r_len);

    assign rx_ready  = r_rx_ready;
    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign count     = r_count;

    // Loader FSM: state, datapath registers and registered outputs together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_im_we     <= 1'b0;
            r_im_addr   <= 8'd0;
            r_im_wdata  <= 15'd0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= 9'd0;
            r_len       <= 9'd0;
            r_timer     <= 16'd0;
            r_opcode    <= 7'd0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            r_im_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    // A new load restarts from address 0 with fresh status.
                    // A byte offered in this cycle is not taken (ready is low).
                    if (start) begin
                        r_state     <= S_LEN;
                        r_rx_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_count     <= 9'd0;
                        r_im_addr   <= 8'd0;
                        r_timer     <= 16'd0;
                    end else begin
                        r_state <= r_state;
                    end
                end

                S_LEN: begin
                    // The header may take arbitrarily long; no timeout here.
                    if (w_xfer) begin
                        r_len   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        r_state <= S_OPC;
                        r_timer <= 16'd0;
                    end else begin
                        r_state <= S_LEN;
                    end
                end

                S_OPC: begin
                    if (w_xfer) begin
                        r_timer <= 16'd0;
                        if (rx_data[7]) begin
                            // Opcodes are 7 bits; a set MSB marks a corrupt stream.
                            r_state     <= S_ERR;
                            r_rx_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_error     <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_opcode <= rx_data[6:0];
                            r_state  <= S_LIT;
                        end
                    end else if (w_timer_expired) begin
                        r_state     <= S_ERR;
                        r_rx_ready  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_cpu_reset <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_LIT: begin
                    if (w_xfer) begin
                        // Word is presented on the bus during the WRITE cycle.
                        r_im_wdata <= {r_opcode, rx_data};
                        r_im_we    <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_timer    <= 16'd0;
                        r_state    <= S_WRITE;
                    end else if (w_timer_expired) begin
                        r_state     <= S_ERR;
                        r_rx_ready  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_cpu_reset <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_WRITE: begin
                    // Address wraps to 0 only after the 256th word.
                    r_count   <= w_count_inc;
                    r_im_addr <= r_im_addr + 8'd1;
                    if (w_last_word) begin
                        r_state     <= S_DONE;
                        r_rx_ready  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state    <= S_OPC;
                        r_rx_ready <= 1'b1;
                        r_timer    <= 16'd0;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a safe, CPU-held state.
                    r_state     <= S_IDLE;
                    r_rx_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Randomized, self-checking bench for program_loader (TIMEOUT = 8).
// Expected write traffic comes from a stream-parsing reference model.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [14:0] im_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    logic [22:0] cap_q[$];   // observed writes {addr, data}
    logic [22:0] exp_q[$];   // model writes {addr, data}
    bit          exp_err;
    int          dbl_cnt = 0;
    logic        prev_we = 1'b0;

    program_loader #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and flag strobes longer than one cycle.
    always @(posedge clk) begin
        if (im_we) cap_q.push_back({im_addr, im_wdata});
        if (im_we && prev_we) dbl_cnt <= dbl_cnt + 1;
        prev_we <= im_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: parse the stream by its own rules.
    task automatic run_model(input logic [7:0] s[$]);
        int n;
        logic [7:0] opc;
        exp_q.delete();
        exp_err = 1'b0;
        n = (s[0] == 8'd0) ? 256 : int'(s[0]);
        for (int k = 0; k < n; k++) begin
            if (1 + 2 * k >= s.size()) break;
            opc = s[1 + 2 * k];
            if (opc[7]) begin
                exp_err = 1'b1;
                break;
            end
            if (2 + 2 * k >= s.size()) break;
            exp_q.push_back({8'(k % 256), opc[6:0], s[2 + 2 * k]});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rdy"},   rx_ready,  32'd0);
        check_eq({tag, "_we"},    im_we,     32'd0);
        check_eq({tag, "_addr"},  im_addr,   32'd0);
        check_eq({tag, "_wdata"}, im_wdata,  32'd0);
        check_eq({tag, "_cpur"},  cpu_reset, 32'd1);
        check_eq({tag, "_busy"},  busy,      32'd0);
        check_eq({tag, "_done"},  done,      32'd0);
        check_eq({tag, "_err"},   error,     32'd0);
        check_eq({tag, "_cnt"},   count,     32'd0);
    endtask

    // Pulse start with a byte offered in the same cycle; it must be ignored.
    task automatic do_start(input logic [7:0] hdr);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = hdr;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Feed bytes with optional random gaps and stray start pulses.
    task automatic send_stream(input logic [7:0] s[$], input int max_gap, input bit poke_start);
        int g;
        int w;
        foreach (s[i]) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                start    = poke_start && ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            start    = 1'b0;
            rx_valid = 1'b1;
            rx_data  = s[i];
            w = 0;
            while (!rx_ready && w < 64) begin
                @(negedge clk);
                w++;
            end
            if (w >= 64) check_eq("rdy_wait", 32'd0, 32'd1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic load_and_check(input string tag, input logic [7:0] s[$], input int max_gap, input bit poke_start);
        int base;
        base = cap_q.size();
        run_model(s);
        do_start(s[0]);
        send_stream(s, max_gap, poke_start);
        if (!exp_err) begin
            check_eq({tag, "_we_lat"}, im_we, 32'd1);
            @(negedge clk);
            check_eq({tag, "_done"}, done,      32'd1);
            check_eq({tag, "_cpur"}, cpu_reset, 32'd0);
            check_eq({tag, "_err"},  error,     32'd0);
            check_eq({tag, "_busy"}, busy,      32'd0);
        end else begin
            @(negedge clk);
            check_eq({tag, "_err"},  error,     32'd1);
            check_eq({tag, "_done"}, done,      32'd0);
            check_eq({tag, "_cpur"}, cpu_reset, 32'd1);
            check_eq({tag, "_busy"}, busy,      32'd0);
        end
        check_eq({tag, "_rdy"}, rx_ready, 32'd0);
        check_eq({tag, "_cnt"}, count, 32'(exp_q.size()));
        check_eq({tag, "_nwr"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
        if (cap_q.size() - base == exp_q.size()) begin
            foreach (exp_q[k]) check_eq({tag, "_word"}, cap_q[base + k], exp_q[k]);
        end
    endtask

    initial begin
        logic [7:0] s[$];
        int n;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_cpur", cpu_reset, 32'd1);

        // Basic two-word load.
        s = '{8'h02, 8'h05, 8'h11, 8'h0A, 8'hFF};
        load_and_check("basic", s, 0, 1'b0);

        // Full 256-word program.
        s.delete();
        s.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            s.push_back({1'b0, 7'(i)});
            s.push_back(8'(i));
        end
        load_and_check("full", s, 0, 1'b0);
        check_eq("full_addr_wrap", im_addr, 32'd0);

        // Malformed opcode after one good word.
        s = '{8'h03, 8'h01, 8'h02, 8'h80};
        load_and_check("badop", s, 0, 1'b0);

        // Stall in OPC: 8 idle cycles abort.
        do_start(8'h01);
        send_stream('{8'h01}, 0, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        check_eq("tmo_pre_err", error,    32'd0);
        check_eq("tmo_pre_rdy", rx_ready, 32'd1);
        @(negedge clk);
        check_eq("tmo_err",  error,     32'd1);
        check_eq("tmo_cpur", cpu_reset, 32'd1);
        check_eq("tmo_busy", busy,      32'd0);

        // Byte arriving in the last allowed cycle wins over the timeout.
        do_start(8'h01);
        send_stream('{8'h01}, 0, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        @(negedge clk);
        check_eq("tmo_win_lit", rx_ready, 32'd1);
        rx_data = 8'h34;
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("tmo_win_we",   im_we,    32'd1);
        check_eq("tmo_win_data", im_wdata, 32'h1234);
        check_eq("tmo_win_addr", im_addr,  32'd0);
        @(negedge clk);
        check_eq("tmo_win_done", done,  32'd1);
        check_eq("tmo_win_err",  error, 32'd0);
        check_eq("tmo_win_cnt",  count, 32'd1);

        // Random programs with gaps and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            s.delete();
            n = $urandom_range(1, 12);
            s.push_back(8'(n));
            for (int k = 0; k < n; k++) begin
                s.push_back(8'($urandom_range(0, 127)));
                s.push_back(8'($urandom_range(0, 255)));
            end
            load_and_check("rand", s, 5, 1'b1);
        end

        // Asynchronous reset in the middle of a 3-word load.
        do_start(8'h03);
        send_stream('{8'h03, 8'h01, 8'h02}, 0, 1'b0);
        @(negedge clk);
        check_eq("mid_cnt", count, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        s = '{8'h03, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        load_and_check("reload", s, 2, 1'b0);

        check_eq("strobe_width", 32'(dbl_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage upstream of the instruction memory.
- Receives a byte stream (length header, then opcode/literal byte pairs) and assembles 15-bit instruction words {opcode[6:0], literal[7:0]}.
- Writes each word to the instruction memory at consecutive addresses starting at 0, and holds the CPU in reset until the program is fully loaded.
- Detects malformed streams and stalled streams.

Parameters:
- TIMEOUT, 1024: max idle cycles allowed between accepted bytes while inside a program body (OPC/LIT states); range 2..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all loader state
- start  in  1  single-cycle pulse; begins a new load from IDLE, DONE or ERR
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data holds a valid byte
- rx_ready  out  1  loader can accept a byte this cycle
- im_we  out  1  instruction memory write strobe, one cycle per word
- im_addr  out  8  instruction memory write address
- im_wdata  out  15  instruction word {opcode, literal}
- cpu_reset  out  1  reset to the CPU datapath (PC, regs, status, data memory)
- busy  out  1  load in progress (LEN, OPC, LIT, WRITE)
- done  out  1  last load completed successfully
- error  out  1  last load aborted
- count  out  9  words written in the current/last load (0..256)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - state=IDLE
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0
  - cpu_reset=1, busy=0, done=0, error=0, count=0
  - internal length=0, timer=0, opcode latch=0
- Handshake:
  - A byte transfers on a rising edge with rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in LEN, OPC and LIT; 0 in all other states.
  - rx_data is don't-care when no transfer occurs.
- States:
  - IDLE: cpu_reset=1. start -> LEN. Also clears done/error/count, sets im_addr=0, timer=0.
  - LEN: accepted byte stored as length N; value 0 means 256 words. -> OPC. No timeout in LEN; the loader waits indefinitely for the header.
  - OPC: on accepted byte:
    - bit7=1 -> ERR.
    - Otherwise latch bits[6:0] as opcode -> LIT.
  - LIT: on accepted byte, im_wdata <= {opcode, byte} -> WRITE.
  - WRITE: exactly one cycle.
    - im_we=1 with im_addr/im_wdata stable.
    - On exit: count+1 and im_addr+1 (8-bit wrap).
    - If count+1 == N (256 when N=0) -> DONE; else -> OPC.
  - DONE: cpu_reset=0, done=1. start -> LEN.
  - ERR: cpu_reset=1, error=1. start -> LEN.
- Latency:
  - im_we is asserted in the cycle immediately after the literal byte is accepted.
  - Minimum 3 cycles per word (OPC, LIT, WRITE).
  - cpu_reset deasserts in the cycle after the final WRITE cycle.
- Timeout:
  - timer clears on every accepted byte and on entry to LEN and OPC.
  - timer increments each cycle in OPC/LIT without a transfer.
  - When timer reaches TIMEOUT-1 with no transfer that cycle -> ERR. A byte accepted in that same cycle wins.
- Outputs:
  - im_we=0 outside WRITE.
  - im_addr/im_wdata hold their last value outside WRITE.
  - count never exceeds 256; im_addr wraps 255->0 only on the 256th write, coincident with entering DONE.
  - done and error are never both 1; busy=0 in IDLE/DONE/ERR.
- Simultaneous and edge events:
  - start while busy is ignored.
  - start and rx_valid in the same cycle from IDLE/DONE/ERR: only the state change occurs; the byte is not accepted (rx_ready=0 that cycle).
- Reset mid-load: asynchronous return to the reset values immediately. Any partial program in instruction memory is left in place (no rewrite). cpu_reset stays 1.

Test Plan:
- Basic load: reset, start, bytes 0x02,0x05,0x11,0x0A,0xFF -> im_we at addr 0 data 0x0511, then addr 1 data 0x0AFF; done=1, cpu_reset=0, count=2, rx_ready=0.
- Full length: start, header 0x00, then 256 pairs (opcode=i[6:0], literal=i) -> 256 writes with addresses 0..255 in order; done after the 256th; count=256; im_addr=0.
- Bad opcode: header 0x03, pair 0x01,0x02, then opcode byte 0x80 -> exactly one write; error=1, cpu_reset=1, done=0, count=1.
- Timeout with TIMEOUT=8: header 0x01, then rx_valid held 0 -> ERR entered after 8 cycles in OPC. Repeat with a byte on cycle 7 -> no error; load completes.
- Backpressure/gaps: rx_valid toggled randomly, start pulsed mid-load -> words identical to the gap-free case; start has no effect; im_we strobes are one cycle each.
- Reset mid-load after 1 of 3 words: reset asserted asynchronously -> all outputs return to reset values before the next edge; a following start plus a full stream loads correctly from addr 0.
